// File: rtl/output_manager_if.sv
`default_nettype none
// ============================================================================
// Module      : output_manager_if
// Description : Bus bundle between output_manager and its neighbours. The
//               render side (pix_*, program_in, resume) and the display side
//               (vga_*, disp_line, status flags) travel together.
//               slave  : output_manager view
//               master : render pipeline + display timing view
// Revision    : 1.0  initial release
// ============================================================================
interface output_manager_if #(
  parameter int COORD_W = 12,
  parameter int DATA_W  = 12
);
  // render pipeline side
  logic               program_in;
  logic               pix_valid;
  logic [COORD_W-1:0] pix_x;
  logic [COORD_W-1:0] pix_y;
  logic [DATA_W-1:0]  pix_data;
  logic               resume;
  // display side
  logic               vga_rd_en;
  logic [COORD_W-1:0] vga_rd_x;
  logic               vga_line_done;
  logic [DATA_W-1:0]  vga_rgb;
  logic               vga_rgb_valid;
  logic [COORD_W-1:0] disp_line;
  logic               underrun;
  logic               overflow;

  modport slave (
    input  program_in, pix_valid, pix_x, pix_y, pix_data,
    input  vga_rd_en, vga_rd_x, vga_line_done,
    output resume, vga_rgb, vga_rgb_valid, disp_line, underrun, overflow
  );

  modport master (
    output program_in, pix_valid, pix_x, pix_y, pix_data,
    output vga_rd_en, vga_rd_x, vga_line_done,
    input  resume, vga_rgb, vga_rgb_valid, disp_line, underrun, overflow
  );
endinterface
`default_nettype wire

// File: rtl/output_manager.sv
`default_nettype none
// ============================================================================
// Module      : output_manager
// Description : Ping-pong scanline buffer at the tail of the render pipeline.
//               One bank is filled from rendered pixels while the other is
//               read by the display; banks swap at line boundaries and a
//               one-cycle resume pulse asks the renderer for the next line.
// Ports       : clk, rst_n (async, active-low)
//               bus.slave : pixel input, programming flush, resume, display
//                           read port, line/underrun/overflow status
// Revision    : 1.0  initial release
// ============================================================================
module output_manager #(
  parameter int SCREEN_WIDTH  = 1024,
  parameter int SCREEN_HEIGHT = 768,
  parameter int COORD_W       = 12,
  parameter int DATA_W        = 12
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  output_manager_if.slave  bus
);

  localparam int               ADDR_W   = $clog2(SCREEN_WIDTH);
  localparam logic [COORD_W:0] WIDTH_C  = (COORD_W+1)'(SCREEN_WIDTH);
  localparam logic [COORD_W:0] HEIGHT_C = (COORD_W+1)'(SCREEN_HEIGHT);
  localparam logic [COORD_W-1:0] LAST_X = COORD_W'(SCREEN_WIDTH - 1);

  typedef enum logic [0:0] {
    FILL      = 1'b0,
    WAIT_SWAP = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic               wr_bank_q, wr_bank_d;
  logic               disp_valid_q, disp_valid_d;
  logic [COORD_W-1:0] wr_line_q, wr_line_d;
  logic [COORD_W-1:0] disp_line_q, disp_line_d;
  logic               resume_q, resume_d;
  logic               underrun_q, underrun_d;
  logic               overflow_q, overflow_d;
  logic               rgb_valid_q, rgb_valid_d;
  logic               rd_zero_q, rd_zero_d;

  // Both banks live in one array; the bank bit is the address MSB.
  logic [DATA_W-1:0]  mem [0:(2 << ADDR_W)-1];
  logic [DATA_W-1:0]  ram_rdata_q;

  logic               pix_in_range;
  logic               rd_in_range;
  logic               wr_en;
  logic               line_complete;
  logic               swap;

  assign pix_in_range  = bus.pix_valid && ({1'b0, bus.pix_x} < WIDTH_C);
  assign rd_in_range   = {1'b0, bus.vga_rd_x} < WIDTH_C;
  assign wr_en         = pix_in_range && !bus.program_in && (state_q == FILL);
  assign line_complete = wr_en && (bus.pix_x == LAST_X);

  // RAM: one write port into wr_bank, one registered read port from the
  // other bank. The banks never coincide, so no read/write collision logic.
  always_ff @(posedge clk) begin
    if (wr_en)
      mem[{wr_bank_q, bus.pix_x[ADDR_W-1:0]}] <= bus.pix_data;
    if (bus.vga_rd_en)
      ram_rdata_q <= mem[{~wr_bank_q, bus.vga_rd_x[ADDR_W-1:0]}];
  end

  always_comb begin
    state_d      = state_q;
    wr_bank_d    = wr_bank_q;
    disp_valid_d = disp_valid_q;
    wr_line_d    = wr_line_q;
    disp_line_d  = disp_line_q;
    underrun_d   = underrun_q;
    overflow_d   = overflow_q;
    resume_d     = 1'b0;
    swap         = 1'b0;

    // Read side keeps tracking even during a flush. rd_zero masks the RAM
    // output for empty display bank or out-of-range columns; both the mask
    // and the RAM register hold when no read is requested.
    rgb_valid_d = bus.vga_rd_en;
    rd_zero_d   = rd_zero_q;
    if (bus.vga_rd_en)
      rd_zero_d = !(disp_valid_q && rd_in_range);

    if (bus.program_in) begin
      state_d      = FILL;
      wr_bank_d    = 1'b0;
      disp_valid_d = 1'b0;
      wr_line_d    = '0;
      disp_line_d  = '0;
      underrun_d   = 1'b0;
      overflow_d   = 1'b0;
    end else begin
      if (wr_en && (bus.pix_x == '0))
        wr_line_d = bus.pix_y;

      case (state_q)
        FILL: begin
          if (line_complete) begin
            if (!disp_valid_q || bus.vga_line_done)
              swap = 1'b1;
            else
              state_d = WAIT_SWAP;
          end else if (bus.vga_line_done && disp_valid_q) begin
            // Display wrapped before the next line was ready; old line repeats.
            underrun_d = 1'b1;
          end
        end
        WAIT_SWAP: begin
          if (pix_in_range)
            overflow_d = 1'b1;
          if (bus.vga_line_done) begin
            swap    = 1'b1;
            state_d = FILL;
          end
        end
        default: state_d = FILL;
      endcase

      if (swap) begin
        wr_bank_d    = ~wr_bank_q;
        disp_valid_d = 1'b1;
        // wr_line_d already includes a same-cycle x==0 latch (1-pixel lines).
        disp_line_d  = ({1'b0, wr_line_d} < HEIGHT_C) ? wr_line_d : '0;
        resume_d     = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= FILL;
      wr_bank_q    <= 1'b0;
      disp_valid_q <= 1'b0;
      wr_line_q    <= '0;
      disp_line_q  <= '0;
      resume_q     <= 1'b0;
      underrun_q   <= 1'b0;
      overflow_q   <= 1'b0;
      rgb_valid_q  <= 1'b0;
      rd_zero_q    <= 1'b1;
    end else begin
      state_q      <= state_d;
      wr_bank_q    <= wr_bank_d;
      disp_valid_q <= disp_valid_d;
      wr_line_q    <= wr_line_d;
      disp_line_q  <= disp_line_d;
      resume_q     <= resume_d;
      underrun_q   <= underrun_d;
      overflow_q   <= overflow_d;
      rgb_valid_q  <= rgb_valid_d;
      rd_zero_q    <= rd_zero_d;
    end
  end

  assign bus.resume        = resume_q;
  assign bus.vga_rgb       = rd_zero_q ? '0 : ram_rdata_q;
  assign bus.vga_rgb_valid = rgb_valid_q;
  assign bus.disp_line     = disp_line_q;
  assign bus.underrun      = underrun_q;
  assign bus.overflow      = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_output_manager.sv
`default_nettype none
// ============================================================================
// Module      : tb_output_manager
// Description : Self-checking bench for output_manager. Read data is checked
//               through an expected-value queue; line sequencing, resume,
//               underrun/overflow, flush and async reset are checked inline.
// Revision    : 1.0  initial release
// ============================================================================
module tb_output_manager;

  localparam int W = 1024;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  output_manager_if #(.COORD_W(12), .DATA_W(12)) bus ();

  output_manager #(
    .SCREEN_WIDTH (1024),
    .SCREEN_HEIGHT(768),
    .COORD_W      (12),
    .DATA_W       (12)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int pass_cnt  = 0;
  int total_cnt = 0;
  logic [11:0] exp_q[$];

  typedef struct {
    logic [11:0] rd_x;
    logic [11:0] exp_rgb;
  } rd_vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Read scoreboard: one expected value per issued read, popped when the
  // registered data appears.
  always begin
    @(posedge clk);
    #2;
    if (rst_n && bus.vga_rgb_valid) begin
      if (exp_q.size() == 0) begin
        total_cnt++;
        $display("FAIL rd_unexpected: got 0x%0h expected no read data", bus.vga_rgb);
      end else begin
        check("rd_data", {20'd0, bus.vga_rgb}, {20'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [11:0] pdata(input int kind, input int x);
    logic [11:0] xv;
    xv = 12'(x);
    case (kind)
      0:       return xv;
      1:       return 12'hF0F;
      2:       return 12'hA00 ^ xv;
      3:       return 12'h555;
      default: return ~xv;
    endcase
  endfunction

  logic res_seen, res_last;

  // Drive pixels x_from..x_to on line y; optional vga_line_done on the last.
  task automatic stream(input int y, input int x_from, input int x_to,
                        input int kind, input bit ld_last);
    res_seen = 1'b0;
    for (int x = x_from; x <= x_to; x++) begin
      bus.pix_valid     = 1'b1;
      bus.pix_x         = 12'(x);
      bus.pix_y         = 12'(y);
      bus.pix_data      = pdata(kind, x);
      bus.vga_line_done = ld_last && (x == x_to);
      step();
      if (x != x_to) res_seen = res_seen | bus.resume;
    end
    res_last          = bus.resume;
    bus.pix_valid     = 1'b0;
    bus.vga_line_done = 1'b0;
  endtask

  task automatic read1(input int x, input logic [11:0] exp);
    bus.vga_rd_en = 1'b1;
    bus.vga_rd_x  = 12'(x);
    exp_q.push_back(exp);
    step();
    bus.vga_rd_en = 1'b0;
  endtask

  rd_vec_t vecs[6];

  initial begin
    vecs[0] = '{12'd5,    12'h005};
    vecs[1] = '{12'd0,    12'h000};
    vecs[2] = '{12'd512,  12'h200};
    vecs[3] = '{12'd1024, 12'h000};
    vecs[4] = '{12'd4095, 12'h000};
    vecs[5] = '{12'd1023, 12'h3FF};

    rst_n             = 1'b0;
    bus.program_in    = 1'b0;
    bus.pix_valid     = 1'b0;
    bus.pix_x         = '0;
    bus.pix_y         = '0;
    bus.pix_data      = '0;
    bus.vga_rd_en     = 1'b0;
    bus.vga_rd_x      = '0;
    bus.vga_line_done = 1'b0;
    repeat (3) step();

    check("rst_resume",    {31'd0, bus.resume},        32'd0);
    check("rst_rgb",       {20'd0, bus.vga_rgb},       32'd0);
    check("rst_rgb_valid", {31'd0, bus.vga_rgb_valid}, 32'd0);
    check("rst_disp_line", {20'd0, bus.disp_line},     32'd0);
    check("rst_underrun",  {31'd0, bus.underrun},      32'd0);
    check("rst_overflow",  {31'd0, bus.overflow},      32'd0);
    rst_n = 1'b1;
    step();

    // Line 0 from startup: immediate swap on x=1023.
    stream(0, 0, W-1, 0, 1'b0);
    check("l0_resume_early", {31'd0, res_seen}, 32'd0);
    check("l0_resume",       {31'd0, res_last}, 32'd1);
    check("l0_disp_line",    {20'd0, bus.disp_line}, 32'd0);
    step();
    check("l0_resume_1cyc",  {31'd0, bus.resume}, 32'd0);

    // Table-driven reads of line 0.
    for (int i = 0; i < 6; i++) begin
      bus.vga_rd_en = 1'b1;
      bus.vga_rd_x  = vecs[i].rd_x;
      exp_q.push_back(vecs[i].exp_rgb);
      step();
    end
    bus.vga_rd_en = 1'b0;
    step();
    step();
    check("rd_hold_valid", {31'd0, bus.vga_rgb_valid}, 32'd0);
    check("rd_hold_data",  {20'd0, bus.vga_rgb},       32'h3FF);

    // Line 1 while line 0 displayed: waits for the display.
    stream(1, 0, W-1, 1, 1'b0);
    check("l1_no_resume", {31'd0, res_seen | res_last}, 32'd0);
    read1(5, 12'h005);
    bus.pix_valid = 1'b1; bus.pix_x = 12'd3; bus.pix_y = 12'd2; bus.pix_data = 12'hBAD;
    step();
    bus.pix_valid = 1'b0;
    check("ovf_set", {31'd0, bus.overflow}, 32'd1);
    bus.vga_line_done = 1'b1;
    step();
    bus.vga_line_done = 1'b0;
    check("l1_resume",    {31'd0, bus.resume},    32'd1);
    check("l1_disp_line", {20'd0, bus.disp_line}, 32'd1);
    check("l1_underrun",  {31'd0, bus.underrun},  32'd0);
    step();
    check("l1_resume_1cyc", {31'd0, bus.resume}, 32'd0);
    read1(5, 12'hF0F);
    read1(1023, 12'hF0F);

    // Line 2 completes together with vga_line_done: immediate swap.
    stream(2, 0, W-1, 2, 1'b1);
    check("l2_no_early_resume", {31'd0, res_seen},      32'd0);
    check("l2_resume",          {31'd0, res_last},      32'd1);
    check("l2_disp_line",       {20'd0, bus.disp_line}, 32'd2);
    check("l2_underrun",        {31'd0, bus.underrun},  32'd0);
    step();
    read1(3, 12'hA03);
    read1(1023, 12'h9FF);
    check("ovf_sticky", {31'd0, bus.overflow}, 32'd1);

    // Underrun: display line ends while line 3 is half filled.
    stream(3, 0, 511, 3, 1'b0);
    bus.vga_line_done = 1'b1;
    step();
    bus.vga_line_done = 1'b0;
    check("ur_set",       {31'd0, bus.underrun}, 32'd1);
    check("ur_no_resume", {31'd0, bus.resume},   32'd0);
    step();
    check("ur_no_resume2", {31'd0, bus.resume},    32'd0);
    check("ur_disp_line",  {20'd0, bus.disp_line}, 32'd2);
    read1(3, 12'hA03);

    // Programming flush mid-line with pixels still arriving.
    bus.program_in = 1'b1;
    bus.pix_valid = 1'b1; bus.pix_x = 12'd512; bus.pix_y = 12'd3; bus.pix_data = 12'h123;
    step();
    bus.pix_x = 12'd513;
    step();
    bus.pix_valid = 1'b0;
    check("prog_overflow",  {31'd0, bus.overflow},  32'd0);
    check("prog_underrun",  {31'd0, bus.underrun},  32'd0);
    check("prog_disp_line", {20'd0, bus.disp_line}, 32'd0);
    check("prog_resume",    {31'd0, bus.resume},    32'd0);
    read1(3, 12'h000);
    bus.program_in = 1'b0;
    step();

    stream(0, 0, W-1, 4, 1'b0);
    check("rf_no_early_resume", {31'd0, res_seen},      32'd0);
    check("rf_resume",          {31'd0, res_last},      32'd1);
    check("rf_disp_line",       {20'd0, bus.disp_line}, 32'd0);
    step();
    read1(0, 12'hFFF);
    read1(1023, 12'hC00);
    step();
    step();

    // Async reset while resume is high.
    stream(1, 0, W-1, 1, 1'b1);
    check("ar_resume_pre", {31'd0, res_last}, 32'd1);
    check("ar_disp_line_pre", {20'd0, bus.disp_line}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("ar_resume",    {31'd0, bus.resume},    32'd0);
    check("ar_disp_line", {20'd0, bus.disp_line}, 32'd0);
    step();
    rst_n = 1'b1;
    step();
    step();
    check("rd_queue_empty", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire
